// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg
// Shared definitions for the byte-stream ROM loader: the loader FSM state
// encoding and the default packet framing / timeout constants.
// No ports (package).

package rom_loader_pkg;

  // Loader FSM states, in the order a packet walks through them.
  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CSUM,
    DONE
  } state_t;

  // Default start-of-packet marker.
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // Default number of idle clocks tolerated between bytes inside a packet.
  localparam int TIMEOUT_CYC_DEF = 50000;

endpackage

// File: rtl/rom_loader_timeout.sv
// rom_loader_timeout
// Inter-byte idle counter for the ROM loader. Counts clocks while enabled and
// not cleared. It fires a one-cycle expire pulse on the clock where the count
// has reached TIMEOUT_CYC-1 and no byte is arriving.
// Ports:
//   clk     in  system clock
//   resetn  in  asynchronous active-low reset
//   clear   in  a byte was accepted this cycle; restart the count
//   enable  in  the loader is inside a packet (LEN/DATA/CSUM)
//   expire  out one-cycle pulse: the idle limit was hit this cycle

module rom_loader_timeout
  import rom_loader_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count;

  // An arriving byte always beats expiry, so clear masks the pulse.
  assign expire = enable && !clear && (count == LAST_CNT);

  // The count is held at zero whenever the loader is outside a packet, so
  // every packet starts with a fresh idle budget. It also restarts after
  // firing because the loader drops back to IDLE on expiry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear || !enable || expire) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rom_loader.sv
// rom_loader
// Byte-stream firmware loader feeding the program ROM write port. It frames
// packets of the form SYNC, LEN, 4*LEN data bytes (little-endian words) and
// CSUM. It writes each assembled word to the ROM and holds the CPU in reset
// until a packet with a matching checksum has been written.
// Ports:
//   clk         in  system clock (rising edge)
//   resetn      in  asynchronous active-low reset
//   rx_valid    in  one-cycle strobe qualifying rx_data
//   rx_data     in  received byte
//   mem_wen     out ROM write enable, one-cycle pulse
//   mem_addr    out ROM word address (holds last written address)
//   mem_wdata   out ROM write data
//   cpu_resetn  out active-low reset to the CPU
//   load_done   out last packet loaded with a good checksum
//   load_err    out sticky error flag, cleared by the next sync byte

module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int         ADDR_W      = 8,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_resetn,
  output logic              load_done,
  output logic              load_err
);

  state_t state, state_nxt;

  logic [1:0]        lane, lane_nxt;
  logic [ADDR_W-1:0] word_idx, word_idx_nxt;
  logic [ADDR_W-1:0] word_cnt, word_cnt_nxt;
  logic [ADDR_W-1:0] last_idx;
  logic [7:0]        csum, csum_nxt;
  logic [31:0]       asm_word, asm_nxt;

  logic              mem_wen_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [31:0]       mem_wdata_nxt;
  logic              cpu_resetn_nxt;
  logic              load_done_nxt;
  logic              load_err_nxt;

  logic              in_packet;
  logic              expire;

  assign in_packet = (state == LEN) || (state == DATA) || (state == CSUM);

  // A word count of zero wraps to all-ones here, which is exactly the last
  // index of a full 2^ADDR_W packet.
  assign last_idx = word_cnt - ADDR_W'(1);

  // Idle counter guarding the gaps between bytes inside a packet.
  rom_loader_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .resetn (resetn),
    .clear  (rx_valid),
    .enable (in_packet),
    .expire (expire)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath and output registers. Every output is taken straight from a
  // flop so that nothing on rx_* reaches the ROM or CPU combinationally.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lane       <= '0;
      word_idx   <= '0;
      word_cnt   <= '0;
      csum       <= '0;
      asm_word   <= '0;
      mem_wen    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_resetn <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      lane       <= lane_nxt;
      word_idx   <= word_idx_nxt;
      word_cnt   <= word_cnt_nxt;
      csum       <= csum_nxt;
      asm_word   <= asm_nxt;
      mem_wen    <= mem_wen_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      cpu_resetn <= cpu_resetn_nxt;
      load_done  <= load_done_nxt;
      load_err   <= load_err_nxt;
    end
  end

  // Next-state and next-output logic. Bytes shift in from the top of the
  // assembly register, so after four of them byte 0 sits in bits [7:0].
  always_comb begin
    state_nxt      = state;
    lane_nxt       = lane;
    word_idx_nxt   = word_idx;
    word_cnt_nxt   = word_cnt;
    csum_nxt       = csum;
    asm_nxt        = asm_word;
    mem_wen_nxt    = 1'b0;
    mem_addr_nxt   = mem_addr;
    mem_wdata_nxt  = mem_wdata;
    cpu_resetn_nxt = cpu_resetn;
    load_done_nxt  = load_done;
    load_err_nxt   = load_err;

    case (state)
      IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          load_err_nxt = 1'b0;
          state_nxt    = LEN;
        end
      end

      LEN: begin
        if (rx_valid) begin
          word_cnt_nxt = ADDR_W'(rx_data);
          word_idx_nxt = '0;
          csum_nxt     = '0;
          lane_nxt     = '0;
          state_nxt    = DATA;
        end else if (expire) begin
          load_err_nxt = 1'b1;
          state_nxt    = IDLE;
        end
      end

      DATA: begin
        if (rx_valid) begin
          csum_nxt = csum + rx_data;
          asm_nxt  = {rx_data, asm_word[31:8]};
          lane_nxt = lane + 2'd1;
          if (lane == 2'd3) begin
            mem_wen_nxt   = 1'b1;
            mem_addr_nxt  = word_idx;
            mem_wdata_nxt = {rx_data, asm_word[31:8]};
            word_idx_nxt  = word_idx + ADDR_W'(1);
            if (word_idx == last_idx) begin
              state_nxt = CSUM;
            end
          end
        end else if (expire) begin
          load_err_nxt = 1'b1;
          state_nxt    = IDLE;
        end
      end

      CSUM: begin
        if (rx_valid) begin
          if (rx_data == csum) begin
            cpu_resetn_nxt = 1'b1;
            load_done_nxt  = 1'b1;
            state_nxt      = DONE;
          end else begin
            load_err_nxt = 1'b1;
            state_nxt    = IDLE;
          end
        end else if (expire) begin
          load_err_nxt = 1'b1;
          state_nxt    = IDLE;
        end
      end

      DONE: begin
        // A new sync byte re-enters the packet directly, putting the CPU
        // back into reset while the new image is written.
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          cpu_resetn_nxt = 1'b0;
          load_done_nxt  = 1'b0;
          state_nxt      = LEN;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader
// Self-checking bench for rom_loader. Directed byte streams drive the loader;
// every expected ROM write is pushed into a scoreboard queue as its 4th byte
// is issued, and a separate monitor pops and compares whenever mem_wen is
// seen. Status outputs are checked directly by the stimulus process.

module tb_rom_loader;

  logic        clk;
  logic        resetn;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        mem_wen;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_resetn;
  logic        load_done;
  logic        load_err;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int cycle_cnt   = 0;
  int check_count = 0;
  int pass_count  = 0;

  rom_loader #(
    .ADDR_W      (8),
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_resetn (cpu_resetn),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle index used to check write latency.
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Bounded run time so a stuck design still ends the simulation.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Present one byte for one cycle (sampled at the next rising edge).
  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
  endtask

  task automatic goIdle();
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // Called in the same cycle the 4th byte is presented: the write must
  // appear in the following cycle.
  task automatic pushExpect(input logic [7:0] addr, input logic [31:0] data);
    exp_t e;
    e.addr = addr;
    e.data = data;
    e.cyc  = cycle_cnt + 1;
    exp_q.push_back(e);
  endtask

  // Send a word as four little-endian bytes and expect it at addr.
  task automatic sendWord(input logic [31:0] w, input logic [7:0] addr);
    applyStimulus(w[7:0]);
    applyStimulus(w[15:8]);
    applyStimulus(w[23:16]);
    applyStimulus(w[31:24]);
    pushExpect(addr, w);
  endtask

  // Write monitor: every mem_wen pulse must match the head of the queue.
  always @(negedge clk) begin
    if (resetn && mem_wen) begin
      if (exp_q.size() == 0) begin
        check_count++;
        $display("[TB] FAIL unexpected_write: actual addr=0x%0h data=0x%0h, required no write",
                 mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("write_addr", 32'(mem_addr), 32'(mon_e.addr));
        checkOutput("write_data", mem_wdata, mon_e.data);
        checkOutput("write_cycle", cycle_cnt, mon_e.cyc);
      end
    end
  end

  initial begin
    logic [7:0]  sum;
    logic [31:0] w;

    rx_valid = 1'b0;
    rx_data  = 8'h00;
    resetn   = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] reset values");
    checkOutput("rst_mem_wen", 32'(mem_wen), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst_cpu_resetn", 32'(cpu_resetn), 32'd0);
    checkOutput("rst_load_done", 32'(load_done), 32'd0);
    checkOutput("rst_load_err", 32'(load_err), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    $display("[TB] good 2-word load");
    applyStimulus(8'hA5);
    applyStimulus(8'h02);
    sendWord(32'h44332211, 8'd0);
    sendWord(32'h88776655, 8'd1);
    applyStimulus(8'h64);
    checkOutput("cpu_resetn_before_csum", 32'(cpu_resetn), 32'd0);
    goIdle();
    checkOutput("good_cpu_resetn", 32'(cpu_resetn), 32'd1);
    checkOutput("good_load_done", 32'(load_done), 32'd1);
    checkOutput("good_load_err", 32'(load_err), 32'd0);
    goIdle();
    checkOutput("addr_hold", 32'(mem_addr), 32'd1);
    checkOutput("wdata_hold", mem_wdata, 32'h88776655);

    $display("[TB] non-sync bytes in DONE");
    applyStimulus(8'h11);
    applyStimulus(8'h02);
    goIdle();
    checkOutput("done_ignore_load_done", 32'(load_done), 32'd1);
    checkOutput("done_ignore_cpu_resetn", 32'(cpu_resetn), 32'd1);

    $display("[TB] reload sync then bad checksum");
    applyStimulus(8'hA5);
    goIdle();
    checkOutput("reload_cpu_resetn", 32'(cpu_resetn), 32'd0);
    checkOutput("reload_load_done", 32'(load_done), 32'd0);
    applyStimulus(8'h02);
    sendWord(32'h44332211, 8'd0);
    sendWord(32'h88776655, 8'd1);
    applyStimulus(8'h65);
    goIdle();
    checkOutput("bad_load_err", 32'(load_err), 32'd1);
    checkOutput("bad_cpu_resetn", 32'(cpu_resetn), 32'd0);
    checkOutput("bad_load_done", 32'(load_done), 32'd0);
    // Back in IDLE: data-looking bytes must produce no writes.
    applyStimulus(8'h02);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    applyStimulus(8'h55);
    goIdle();
    repeat (20) @(negedge clk);
    checkOutput("err_sticky", 32'(load_err), 32'd1);
    applyStimulus(8'hA5);
    goIdle();
    checkOutput("sync_clears_err", 32'(load_err), 32'd0);
    applyStimulus(8'h02);
    sendWord(32'h44332211, 8'd0);
    sendWord(32'h88776655, 8'd1);
    applyStimulus(8'h64);
    goIdle();
    checkOutput("recover_cpu_resetn", 32'(cpu_resetn), 32'd1);
    checkOutput("recover_load_done", 32'(load_done), 32'd1);

    $display("[TB] timeout after 16 idle cycles");
    applyStimulus(8'hA5);
    applyStimulus(8'h01);
    applyStimulus(8'h11);
    goIdle();
    repeat (15) @(negedge clk);
    checkOutput("tmo_not_yet", 32'(load_err), 32'd0);
    @(negedge clk);
    checkOutput("tmo_load_err", 32'(load_err), 32'd1);
    checkOutput("tmo_cpu_resetn", 32'(cpu_resetn), 32'd0);
    checkOutput("tmo_load_done", 32'(load_done), 32'd0);
    checkOutput("tmo_addr_hold", 32'(mem_addr), 32'd1);

    $display("[TB] byte on the expiry cycle");
    applyStimulus(8'hA5);
    applyStimulus(8'h01);
    applyStimulus(8'h11);
    goIdle();
    repeat (14) @(negedge clk);
    applyStimulus(8'h22);
    goIdle();
    checkOutput("expiry_byte_wins", 32'(load_err), 32'd0);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    pushExpect(8'd0, 32'h44332211);
    applyStimulus(8'hAA);
    goIdle();
    checkOutput("expiry_load_done", 32'(load_done), 32'd1);
    checkOutput("expiry_cpu_resetn", 32'(cpu_resetn), 32'd1);

    $display("[TB] LEN=0 full 256-word load");
    applyStimulus(8'hA5);
    applyStimulus(8'h00);
    sum = 8'h00;
    for (int i = 0; i < 256; i++) begin
      w = {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)};
      sum = sum + w[7:0] + w[15:8] + w[23:16] + w[31:24];
      sendWord(w, 8'(i));
    end
    applyStimulus(sum);
    goIdle();
    checkOutput("full_load_done", 32'(load_done), 32'd1);
    checkOutput("full_cpu_resetn", 32'(cpu_resetn), 32'd1);
    checkOutput("full_last_addr", 32'(mem_addr), 32'hFF);
    checkOutput("full_load_err", 32'(load_err), 32'd0);

    $display("[TB] reset mid-DATA");
    applyStimulus(8'hA5);
    applyStimulus(8'h01);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    @(negedge clk);
    rx_valid = 1'b0;
    resetn   = 1'b0;
    #1;
    checkOutput("mid_rst_mem_wen", 32'(mem_wen), 32'd0);
    checkOutput("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("mid_rst_mem_wdata", mem_wdata, 32'd0);
    checkOutput("mid_rst_cpu_resetn", 32'(cpu_resetn), 32'd0);
    checkOutput("mid_rst_load_done", 32'(load_done), 32'd0);
    checkOutput("mid_rst_load_err", 32'(load_err), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    // Rest of the aborted word: loader is in IDLE, nothing may be written.
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    applyStimulus(8'h55);
    applyStimulus(8'h66);
    goIdle();
    applyStimulus(8'hA5);
    applyStimulus(8'h01);
    sendWord(32'hDEADBEEF, 8'd0);
    applyStimulus(8'h38);
    goIdle();
    checkOutput("post_rst_load_done", 32'(load_done), 32'd1);
    checkOutput("post_rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("post_rst_wdata", mem_wdata, 32'hDEADBEEF);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
